// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Decodes the instruction arriving from the memory stage,
// writes the selected result to the register file, diverts writes to r0 into a
// console byte FIFO, latches a sticky halt on any unrecognised opcode and
// counts retired instructions.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     instruction handshake with the memory stage
//   instr_in                16-bit instruction word
//   alu_result, mem_result  candidate write-back values
//   we, waddr, wdata        register-file write port (combinational)
//   con_valid, con_data,
//   con_ready               console byte stream (FIFO head)
//   halted, halt_done       sticky halt, and halt with console drained
//   retired                 number of accepted instructions
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W    = 16,
    parameter int CON_DEPTH = 8,
    parameter int RET_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_result,
    output logic              we,
    output logic [3:0]        waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              halted,
    output logic              halt_done,
    output logic [RET_W-1:0]  retired
);

    localparam int PTR_W = $clog2(CON_DEPTH);

    logic [3:0]        opcode_h_s;
    logic [3:0]        opcode_l_s;
    logic [3:0]        rd_s;
    logic              is_load_s;
    logic              writer_s;
    logic              nonhalt_s;
    logic              halting_s;
    logic              console_s;
    logic [DATA_W-1:0] result_s;

    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;
    logic [7:0]        fifo_mem_r [CON_DEPTH];
    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    logic              halted_r;
    logic [RET_W-1:0]  retired_r;

    // Instruction decode and result selection.
    always_comb begin
        opcode_h_s = instr_in[15:12];
        opcode_l_s = instr_in[7:4];
        rd_s       = instr_in[3:0];
        is_load_s  = (opcode_h_s == 4'hF) && (opcode_l_s == 4'h0);
        writer_s   = (opcode_h_s == 4'h0) || (opcode_h_s == 4'h8) ||
                     (opcode_h_s == 4'h9) || is_load_s;
        nonhalt_s  = ((opcode_h_s == 4'hE) || (opcode_h_s == 4'hF)) &&
                     (opcode_l_s <= 4'h3) && !writer_s;
        halting_s  = !writer_s && !nonhalt_s;
        // A write to r0 is the console output channel, not a register write.
        console_s  = writer_s && (rd_s == 4'h0);
        if (is_load_s) begin
            result_s = mem_result;
        end else begin
            result_s = alu_result;
        end
    end

    // FIFO status from the extra wrap bit of each pointer.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                  (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    end

    // Handshake, register-file port and console/status outputs.
    always_comb begin
        // Only a console write can stall; bubbles pass whenever not halted.
        // Gating with rst_n keeps every side effect quiet during reset.
        in_ready  = rst_n && !halted_r && !(in_valid && console_s && full_s);
        accept_s  = in_valid && in_ready;
        push_s    = accept_s && console_s;
        pop_s     = con_ready && !empty_s;
        we        = accept_s && writer_s && (rd_s != 4'h0);
        waddr     = rd_s;
        wdata     = result_s;
        con_valid = !empty_s;
        con_data  = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
        halted    = halted_r;
        halt_done = halted_r && empty_s;
        retired   = retired_r;
    end

    // Console FIFO storage; contents need no reset because pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= result_s[7:0];
        end
    end

    // FIFO pointers, sticky halt flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {(PTR_W+1){1'b0}};
            rd_ptr_r  <= {(PTR_W+1){1'b0}};
            halted_r  <= 1'b0;
            retired_r <= {RET_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (accept_s && halting_s) begin
                halted_r <= 1'b1;
            end
            if (accept_s) begin
                retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Self-checking bench for writeback_stage. Register writes and console bytes
// are predicted into queues when stimulus is driven and popped when the DUT
// presents them. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int DATA_W    = 16;
    localparam int CON_DEPTH = 8;
    localparam int RET_W     = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr_in;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_result;
    logic              we;
    logic [3:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              con_ready;
    logic              halted;
    logic              halt_done;
    logic [RET_W-1:0]  retired;

    int n_checks;
    int n_fail;

    logic [7:0]        con_q [$];
    logic [3:0]        wa_q  [$];
    logic [DATA_W-1:0] wd_q  [$];
    int                exp_count;
    logic [RET_W-1:0]  exp_retired;

    writeback_stage #(
        .DATA_W    (DATA_W),
        .CON_DEPTH (CON_DEPTH),
        .RET_W     (RET_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_in   (instr_in),
        .alu_result (alu_result),
        .mem_result (mem_result),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .con_valid  (con_valid),
        .con_data   (con_data),
        .con_ready  (con_ready),
        .halted     (halted),
        .halt_done  (halt_done),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        instr_in   = 16'h0123;
        alu_result = 16'h00AB;
        mem_result = 16'h0000;
        con_ready  = 1'b0;
        #12;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
        n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL reset_con_valid: got %b expected 0", con_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (halt_done !== 1'b0) begin n_fail++; $display("FAIL reset_halt_done: got %b expected 0", halt_done); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        @(posedge clk); #1;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        exp_retired = 32'd0;
        exp_count   = 0;
    endtask

    task automatic test_writes();
        logic [15:0] instr_t [8] = '{16'h0123, 16'hF005, 16'h8007, 16'h900A,
                                      16'hE012, 16'hF032, 16'hF010, 16'hE00F};
        logic [15:0] alu_t   [8] = '{16'h00AB, 16'h5678, 16'hBEEF, 16'h0C0C,
                                      16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [15:0] mem_t   [8] = '{16'h9999, 16'h1234, 16'h1111, 16'h7777,
                                      16'h5555, 16'h6666, 16'h8888, 16'hAAAA};
        for (int i = 0; i < 8; i++) begin
            logic [3:0] h;
            logic [3:0] l;
            logic       wr;
            h  = instr_t[i][15:12];
            l  = instr_t[i][7:4];
            wr = (h == 4'h0) || (h == 4'h8) || (h == 4'h9) || (h == 4'hF && l == 4'h0);
            in_valid   = 1'b1;
            instr_in   = instr_t[i];
            alu_result = alu_t[i];
            mem_result = mem_t[i];
            if (wr && instr_t[i][3:0] != 4'h0) begin
                wa_q.push_back(instr_t[i][3:0]);
                wd_q.push_back((h == 4'hF) ? mem_t[i] : alu_t[i]);
            end
            exp_retired++;
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready[%0d]: got %b expected 1", i, in_ready); end
            n_checks++;
            if (we === 1'b1) begin
                if (wa_q.size() == 0) begin
                    n_fail++; $display("FAIL wr_spurious[%0d]: got we=1 expected we=0", i);
                end else begin
                    logic [3:0]        ea;
                    logic [DATA_W-1:0] ed;
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    if (waddr !== ea || wdata !== ed) begin
                        n_fail++; $display("FAIL wr_data[%0d]: got %h/%h expected %h/%h", i, waddr, wdata, ea, ed);
                    end
                end
            end else if (wa_q.size() != 0) begin
                n_fail++; $display("FAIL wr_missing[%0d]: got we=%b expected we=1", i, we);
                void'(wa_q.pop_front());
                void'(wd_q.pop_front());
            end
            @(posedge clk); #1;
            n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL wr_retired[%0d]: got %0d expected %0d", i, retired, exp_retired); end
            n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wr_halted[%0d]: got %b expected 0", i, halted); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubble();
        in_valid = 1'b0;
        instr_in = 16'h2000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL bubble_we: got %b expected 0", we); end
            @(posedge clk); #1;
            n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL bubble_halted: got %b expected 0", halted); end
            n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL bubble_retired: got %0d expected %0d", retired, exp_retired); end
        end
    endtask

    task automatic test_console();
        int pushed;
        pushed = 0;
        for (int c = 0; c < 40 && !(pushed == 9 && exp_count == 0); c++) begin
            logic [7:0] b;
            logic       exp_rdy;
            logic       popped;
            b          = 8'h41 + 8'(pushed);
            in_valid   = (pushed < 9);
            instr_in   = 16'h0000;
            alu_result = {8'h5A, b};
            con_ready  = (c >= 9);
            exp_rdy    = (exp_count < CON_DEPTH);
            @(negedge clk);
            if (in_valid) begin
                n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL con_ready_stall[c%0d]: got %b expected %b", c, in_ready, exp_rdy); end
            end
            n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL con_we[c%0d]: got %b expected 0", c, we); end
            n_checks++; if (con_valid !== (exp_count > 0)) begin n_fail++; $display("FAIL con_valid[c%0d]: got %b expected %b", c, con_valid, exp_count > 0); end
            if (exp_count > 0) begin
                n_checks++; if (con_data !== con_q[0]) begin n_fail++; $display("FAIL con_data[c%0d]: got %h expected %h", c, con_data, con_q[0]); end
            end
            popped = con_ready && (exp_count > 0);
            if (popped) void'(con_q.pop_front());
            if (in_valid && exp_rdy) begin
                con_q.push_back(b);
                pushed++;
                exp_retired++;
                exp_count++;
            end
            if (popped) exp_count--;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (pushed != 9 || exp_count != 0) begin n_fail++; $display("FAIL con_timeout: got pushed=%0d left=%0d expected 9/0", pushed, exp_count); end
        n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL con_drained: got %b expected 0", con_valid); end
        n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL con_retired: got %0d expected %0d", retired, exp_retired); end
    endtask

    task automatic test_halt();
        logic [7:0] bytes_t [3] = '{8'h78, 8'h79, 8'h7A};
        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            instr_in   = 16'h0000;
            alu_result = {8'h00, bytes_t[i]};
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL halt_fill_ready[%0d]: got %b expected 1", i, in_ready); end
            con_q.push_back(bytes_t[i]);
            exp_count++;
            exp_retired++;
            @(posedge clk); #1;
        end
        instr_in   = 16'h2000;
        alu_result = 16'h00EE;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL halt_accept: got ready=%b we=%b expected 1/0", in_ready, we); end
        exp_retired++;
        @(posedge clk); #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b expected 1", halted); end
        instr_in   = 16'h0123;
        alu_result = 16'h0011;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL halt_block: got ready=%b we=%b expected 0/0", in_ready, we); end
        n_checks++; if (halt_done !== 1'b0) begin n_fail++; $display("FAIL halt_done_early: got %b expected 0", halt_done); end
        @(posedge clk); #1;
        con_ready = 1'b1;
        for (int c = 0; c < 10 && exp_count > 0; c++) begin
            @(negedge clk);
            n_checks++; if (con_valid !== 1'b1 || con_data !== con_q[0]) begin n_fail++; $display("FAIL halt_drain[c%0d]: got %b/%h expected 1/%h", c, con_valid, con_data, con_q[0]); end
            n_checks++; if (in_ready !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL halt_quiet[c%0d]: got ready=%b we=%b expected 0/0", c, in_ready, we); end
            void'(con_q.pop_front());
            exp_count--;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (halt_done !== 1'b1 || con_valid !== 1'b0) begin n_fail++; $display("FAIL halt_done: got done=%b valid=%b expected 1/0", halt_done, con_valid); end
        n_checks++; if (retired !== exp_retired || halted !== 1'b1) begin n_fail++; $display("FAIL halt_retired: got %0d/%b expected %0d/1", retired, halted, exp_retired); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        exp_retired = 32'd0;
        con_ready   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid   = 1'b1;
            instr_in   = 16'h0000;
            alu_result = 16'h0030 + 16'(i);
            @(posedge clk); #1;
        end
        instr_in = 16'h3000;
        @(posedge clk); #1;
        n_checks++; if (halted !== 1'b1 || con_valid !== 1'b1 || retired !== 32'd5) begin n_fail++; $display("FAIL mid_pre: got halted=%b valid=%b retired=%0d expected 1/1/5", halted, con_valid, retired); end
        instr_in   = 16'h0123;
        alu_result = 16'h0077;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (con_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got valid=%b halted=%b expected 0/0", con_valid, halted); end
        n_checks++; if (retired !== 32'd0 || halt_done !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_misc: got retired=%0d done=%b we=%b expected 0/0/0", retired, halt_done, we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        con_q.delete();
        exp_count   = 0;
        exp_retired = 32'd1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || we !== 1'b1 || waddr !== 4'd3 || wdata !== 16'h0077) begin n_fail++; $display("FAIL mid_restart: got ready=%b we=%b %h/%h expected 1/1 3/0077", in_ready, we, waddr, wdata); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (retired !== exp_retired || con_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: got retired=%0d valid=%b expected %0d/0", retired, con_valid, exp_retired); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_writes();
        test_bubble();
        test_console();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
